instruction_fetch: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter and the instruction memory, and registers the IF/ID pipeline latch that feeds instruction decode. Supports hazard stalls, branch/jump redirect with flush, HALT detection, and a program-load write port used by the debug unit.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/instr_mem.sv | 27 ++
 rtl/instruction_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, opcode/NOP encodings, PC-source selects
// and the IF/ID latch payload.
package mips_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned PC_SRC_W  = 2;
    localparam int unsigned PC_STEP   = 4;

    localparam logic [OPCODE_W-1:0] OPCODE_HALT = 6'b111111;
    localparam logic [XLEN-1:0]     INSTR_NOP   = 32'h0000_0000;

    localparam logic [PC_SRC_W-1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [PC_SRC_W-1:0] PC_SRC_REG    = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [XLEN-1:0] word);
        return word[XLEN-1 -: OPCODE_W] == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: MEM_DEPTH x 32 register array, combinational read,
// synchronous program-load write. Contents are not affected by reset.
module instr_mem
    import mips_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [MEM_AW-1:0] i_wr_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    input  logic [MEM_AW-1:0] i_rd_addr,
    output logic [XLEN-1:0]   o_rd_data_c
);

    logic [XLEN-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, next-PC mux, IF/ID latch and HALT tracking around instr_mem.
// Optional debug single-step input i_step is enabled with `define IF_STEP_EN.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [PC_SRC_W-1:0] i_pc_src,
    input  logic [XLEN-1:0]     i_branch_target,
    input  logic [XLEN-1:0]     i_jump_target,
    input  logic [XLEN-1:0]     i_reg_target,
    input  logic                i_wr_en,
    input  logic [MEM_AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_data,
`ifdef IF_STEP_EN
    input  logic                i_step,
`endif
    output logic [XLEN-1:0]     o_instr,
    output logic [XLEN-1:0]     o_pc_plus4,
    output logic                o_valid,
    output logic                o_halted,
    output logic [XLEN-1:0]     o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_rd_data;
    logic            w_hold;
    ifid_t           r_ifid;
    ifid_t           w_ifid_next;
    fetch_state_e    r_state;
    fetch_state_e    w_state_next;

    instr_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_AW    (MEM_AW)
    ) u_instr_mem (
        .i_clk       (i_clk),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_rd_addr   (r_pc[MEM_AW+1:2]),
        .o_rd_data_c (w_rd_data)
    );

    // A deasserted step request freezes fetch exactly like a hazard stall.
`ifdef IF_STEP_EN
    assign w_hold = i_stall | ~i_step;
`else
    assign w_hold = i_stall;
`endif

    assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

    // Next PC / IF/ID / halt state, in priority order below reset.
    always_comb begin
        w_pc_next    = r_pc;
        w_ifid_next  = r_ifid;
        w_state_next = r_state;

        if (i_wr_en) begin
            w_pc_next = r_pc;
        end else if (i_flush) begin
            case (i_pc_src)
                PC_SRC_PLUS4:  w_pc_next = w_pc_plus4;
                PC_SRC_BRANCH: w_pc_next = i_branch_target;
                PC_SRC_JUMP:   w_pc_next = i_jump_target;
                PC_SRC_REG:    w_pc_next = i_reg_target;
                default:       w_pc_next = w_pc_plus4;
            endcase
            w_ifid_next.instr = INSTR_NOP;
            w_ifid_next.valid = 1'b0;
            w_state_next      = FS_RUN;
        end else if (w_hold) begin
            w_pc_next = r_pc;
        end else if (r_state == FS_HALT) begin
            w_ifid_next.instr = INSTR_NOP;
            w_ifid_next.valid = 1'b0;
        end else begin
            w_ifid_next.instr    = w_rd_data;
            w_ifid_next.pc_plus4 = w_pc_plus4;
            w_ifid_next.valid    = 1'b1;
            // HALT enters IF/ID but the PC parks on its address.
            if (is_halt(w_rd_data)) begin
                w_state_next = FS_HALT;
            end else begin
                w_pc_next = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= '0;
            r_ifid  <= '0;
            r_state <= FS_RUN;
        end else begin
            r_pc    <= w_pc_next;
            r_ifid  <= w_ifid_next;
            r_state <= w_state_next;
        end
    end

    assign o_instr    = r_ifid.instr;
    assign o_pc_plus4 = r_ifid.pc_plus4;
    assign o_valid    = r_ifid.valid;
    assign o_halted   = (r_state == FS_HALT);
    assign o_pc       = r_pc;

endmodule
